// File: rtl/code.sv
// Four-button password authenticator (code T,L,L,R) driving a 3-digit multiplexed seven-segment display.
// Optional `DEBOUNCE_EN adds a per-button stable-level filter ahead of edge detection.
module code #(
  parameter int REFRESH_BITS    = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       T,
  input  logic       D,
  input  logic       L,
  input  logic       R,
  output logic [6:0] SSG_D,
  output logic [2:0] SSG_EN
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    E0, E1, E2, E3, X1, X2, X3, ST_OPEN, ST_FAIL
  } state_e;

  // Button vector order: bit0=T, bit1=D, bit2=L, bit3=R.
  localparam logic [3:0] KEY_T = 4'b0001;
  localparam logic [3:0] KEY_L = 4'b0100;
  localparam logic [3:0] KEY_R = 4'b1000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [3:0] sync1_q, sync2_q, lvl_prev_q, press_q;
  logic [3:0] lvl;

`ifdef DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] db_cnt_q [4];
  logic [3:0]    filt_q;

  // Filtered level follows the raw level only after DEBOUNCE_CYCLES consecutive disagreeing clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= {R, L, D, T};
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
      press_q    <= lvl & ~lvl_prev_q;
    end
  end

  state_e state_q;

  // A multi-key pulse never equals a single KEY_* code, so it falls through to the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= E0;
    end else if (|press_q) begin
      case (state_q)
        E0:      state_q <= (press_q == KEY_T) ? E1 : X1;
        E1:      state_q <= (press_q == KEY_L) ? E2 : X2;
        E2:      state_q <= (press_q == KEY_L) ? E3 : X3;
        E3:      state_q <= (press_q == KEY_R) ? ST_OPEN : ST_FAIL;
        X1:      state_q <= X2;
        X2:      state_q <= X3;
        X3:      state_q <= ST_FAIL;
        default: state_q <= state_q;
      endcase
    end
  end

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              idx_q;
  logic [6:0]              seg_d;
  logic [1:0]              n_dash;

  always_comb begin
    n_dash = 2'd0;
    seg_d  = SEG_BLANK;
    case (state_q)
      E1, X1:  n_dash = 2'd1;
      E2, X2:  n_dash = 2'd2;
      E3, X3:  n_dash = 2'd3;
      default: n_dash = 2'd0;
    endcase
    case (state_q)
      ST_OPEN: begin
        case (idx_q)
          2'd0:    seg_d = 7'h2B;
          2'd1:    seg_d = 7'h0C;
          default: seg_d = 7'h40;
        endcase
      end
      ST_FAIL: begin
        case (idx_q)
          2'd0, 2'd1: seg_d = 7'h2F;
          default:    seg_d = 7'h06;
        endcase
      end
      default: begin
        // Dashes fill from the left digit (index 2) toward the right.
        case (idx_q)
          2'd0:    seg_d = (n_dash >= 2'd3) ? SEG_DASH : SEG_BLANK;
          2'd1:    seg_d = (n_dash >= 2'd2) ? SEG_DASH : SEG_BLANK;
          default: seg_d = (n_dash >= 2'd1) ? SEG_DASH : SEG_BLANK;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      SSG_D     <= SEG_BLANK;
      SSG_EN    <= 3'b111;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      if (&refresh_q) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      SSG_D <= seg_d;
      case (idx_q)
        2'd0:    SSG_EN <= 3'b110;
        2'd1:    SSG_EN <= 3'b101;
        default: SSG_EN <= 3'b011;
      endcase
    end
  end

endmodule

// File: tb/tb_code.sv
// Randomized bench for the password authenticator: a press-count model predicts
// the display on every clock, with literal digit checks for the directed scenarios.
module tb_code;

  localparam int RB   = 2;
  localparam int SLOT = 1 << RB;
  localparam int HN   = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       T = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0;
  logic [6:0] SSG_D;
  logic [2:0] SSG_EN;

  always #5 clk = ~clk;

  code #(.REFRESH_BITS(RB), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .T(T), .D(D), .L(L), .R(R),
    .SSG_D(SSG_D), .SSG_EN(SSG_EN)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: button history by cycle, number of presses taken (0..4) and a wrong flag.
  logic [3:0] hist [HN];
  int         cyc = 0;
  int         last_rst = -100;
  int         since = 0;
  int         m_n = 0;
  bit         m_wrong = 1'b0;
  bit         chk_en = 1'b0;
  logic [6:0] exp_d;
  logic [2:0] exp_en;

  function automatic logic [3:0] h(int k);
    if (k <= last_rst || k < 0) return 4'b0;
    return hist[k % HN];
  endfunction

  // pos: 0=right, 1=middle, 2=left
  function automatic logic [6:0] digit(int n, bit wrong, int pos);
    if (n == 4) begin
      if (!wrong) return (pos == 2) ? 7'h40 : (pos == 1) ? 7'h0C : 7'h2B;
      else        return (pos == 2) ? 7'h06 : 7'h2F;
    end
    return (n >= 3 - pos) ? 7'h3F : 7'h7F;
  endfunction

  // A rise seen at clock e-4 -> e-3 reaches the code checker at clock e.
  always @(posedge clk) begin
    logic [3:0] p;
    int idx;
    cyc++;
    hist[cyc % HN] = {R, L, D, T};
    if (rst) begin
      exp_d    = 7'h7F;
      exp_en   = 3'b111;
      m_n      = 0;
      m_wrong  = 1'b0;
      last_rst = cyc;
      since    = 0;
      chk_en   = 1'b1;
    end else begin
      since++;
      idx    = ((since - 1) / SLOT) % 3;
      exp_en = ~(3'b001 << idx);
      exp_d  = digit(m_n, m_wrong, idx);
      p = h(cyc - 3) & ~h(cyc - 4);
      if (p != 4'b0 && m_n < 4) begin
        if (!((m_n == 0 && p == 4'b0001) || (m_n == 1 && p == 4'b0100) ||
              (m_n == 2 && p == 4'b0100) || (m_n == 3 && p == 4'b1000)))
          m_wrong = 1'b1;
        m_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (SSG_D !== exp_d || SSG_EN !== exp_en) begin
        miscompares++;
        $display("FAIL display cyc=%0d: got SSG_D=%h SSG_EN=%b, want SSG_D=%h SSG_EN=%b",
                 cyc, SSG_D, SSG_EN, exp_d, exp_en);
      end
    end
  end

  // Drivers: all called at a negedge, return at a negedge.
  task automatic press(input logic [3:0] m, input int width, input int gap);
    {R, L, D, T} = m;
    repeat (width) @(negedge clk);
    {R, L, D, T} = 4'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (SSG_D !== 7'h7F || SSG_EN !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_out: got SSG_D=%h SSG_EN=%b, want 7f 111", SSG_D, SSG_EN);
    end
    rst = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_model(input int n, input bit wrong, input string name);
    vectors++;
    if (m_n != n || m_wrong != wrong) begin
      miscompares++;
      $display("FAIL %s: model n=%0d wrong=%0d, want n=%0d wrong=%0d", name, m_n, m_wrong, n, wrong);
    end
  endtask

  // Observe one full refresh cycle and compare each digit with literal codes.
  task automatic check_digits(input logic [6:0] l, input logic [6:0] m, input logic [6:0] r,
                              input string name);
    logic [6:0] gl, gm, gr;
    gl = 'x; gm = 'x; gr = 'x;
    repeat (3 * SLOT) begin
      @(negedge clk);
      case (SSG_EN)
        3'b110:  gr = SSG_D;
        3'b101:  gm = SSG_D;
        3'b011:  gl = SSG_D;
        default: ;
      endcase
    end
    vectors += 3;
    if (gl !== l) begin miscompares++; $display("FAIL %s left: got %h want %h", name, gl, l); end
    if (gm !== m) begin miscompares++; $display("FAIL %s middle: got %h want %h", name, gm, m); end
    if (gr !== r) begin miscompares++; $display("FAIL %s right: got %h want %h", name, gr, r); end
  endtask

  localparam logic [3:0] BT = 4'b0001, BD = 4'b0010, BL = 4'b0100, BR = 4'b1000;

  initial begin
    logic [3:0] m;
    repeat (3) @(negedge clk);

    // Correct code opens; further keys are ignored.
    do_reset();
    press(BT, 1, 2); press(BL, 1, 2); press(BL, 1, 2); press(BR, 1, 2);
    settle();
    check_model(4, 1'b0, "open_model");
    check_digits(7'h40, 7'h0C, 7'h2B, "open");
    press(BD, 1, 2); press(BT, 1, 2); press(BR, 1, 2);
    settle();
    check_digits(7'h40, 7'h0C, 7'h2B, "open_stays");

    // Wrong first key: three dashes only, then error after the fourth.
    do_reset();
    press(BD, 1, 2); press(BL, 1, 2); press(BL, 1, 2);
    settle();
    check_digits(7'h3F, 7'h3F, 7'h3F, "no_early");
    press(BR, 1, 2);
    settle();
    check_model(4, 1'b1, "fail_model");
    check_digits(7'h06, 7'h2F, 7'h2F, "fail");
    press(BT, 1, 2); press(BL, 1, 2); press(BL, 1, 2); press(BR, 1, 2);
    settle();
    check_digits(7'h06, 7'h2F, 7'h2F, "fail_stays");

    // Partial entry then reset mid-entry.
    do_reset();
    press(BT, 1, 2); press(BL, 1, 2);
    settle();
    check_model(2, 1'b0, "partial_model");
    check_digits(7'h3F, 7'h3F, 7'h7F, "partial");
    do_reset();
    check_digits(7'h7F, 7'h7F, 7'h7F, "blank_after_rst");

    // Simultaneous keys count as one wrong entry.
    do_reset();
    press(BT | BL, 1, 2); press(BL, 1, 2); press(BL, 1, 2); press(BR, 1, 2);
    settle();
    check_digits(7'h06, 7'h2F, 7'h2F, "simul_fail");

    // A held button is a single press.
    do_reset();
    press(BT, 20, 3); press(BL, 2, 1); press(BL, 2, 1); press(BR, 2, 1);
    settle();
    check_digits(7'h40, 7'h0C, 7'h2B, "held_open");

    // Random traffic, weighted toward the correct code so both outcomes occur.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      case ($urandom_range(0, 5))
        0:       m = 4'($urandom_range(1, 15));
        1:       m = 4'b0001 << $urandom_range(0, 3);
        default: m = (m_n == 0) ? BT : (m_n == 3) ? BR : BL;
      endcase
      press(m, $urandom_range(1, 4), $urandom_range(1, 5));
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
